// File: rtl/contador_cm_param_pkg.sv
// Shared definitions for the parametrised echo-pulse to centimetre converter.
package contador_cm_param_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 8;

    typedef enum logic [2:0] {
        INICIAL   = 3'b000,
        ESPERA    = 3'b001,
        CONTA     = 3'b010,
        ARREDONDA = 3'b011,
        ESTOURO   = 3'b100,
        CARREGA   = 3'b101,
        FINAL     = 3'b110
    } estado_t;

    // Adds one to the lowest n BCD digits of v; a carry out of digit n-1 is dropped.
    function automatic logic [BCD_W*MAX_DIGITS-1:0] bcd_inc(
        input logic [BCD_W*MAX_DIGITS-1:0] v,
        input int n
    );
        logic [BCD_W*MAX_DIGITS-1:0] r;
        logic carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (carry && (i < n)) begin
                if (r[i*BCD_W +: BCD_W] == 4'd9) begin
                    r[i*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [BCD_W*MAX_DIGITS-1:0] to_bcd(input int val);
        logic [BCD_W*MAX_DIGITS-1:0] r;
        int v;
        r = '0;
        v = val;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[i*BCD_W +: BCD_W] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/contador_cm_param_bcd.sv
// N-digit BCD up-counter with synchronous clear and a compare against the saturation value.
module contador_bcd_n
    import contador_cm_param_pkg::*;
#(
    parameter int N_DIGITS = 3,
    parameter int MAX_CM   = 400
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      zera,
    input  logic                      conta,
    output logic [BCD_W*N_DIGITS-1:0] q,
    output logic                      eh_max
);

    localparam int QW = BCD_W * N_DIGITS;
    localparam int FW = BCD_W * MAX_DIGITS;
    localparam logic [QW-1:0] MAX_BCD = QW'(to_bcd(MAX_CM));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (zera) begin
            q <= '0;
        end else if (conta) begin
            q <= QW'(bcd_inc(FW'(q), N_DIGITS));
        end
    end

    assign eh_max = (q == MAX_BCD);

endmodule

// File: rtl/contador_cm_param.sv
// Echo-pulse to centimetre converter: pulso synchroniser, cm tick divider, sequencing FSM and result register.
//   state     | meaning
//   INICIAL   | idle, counters cleared, waits for an armed rising pulse
//   ESPERA    | pulse high, dividing clocks into cm ticks
//   CONTA     | a tick elapsed, BCD result advances
//   ARREDONDA | pulse over, partial tick optionally rounds up
//   ESTOURO   | result saturated at MAX_CM, waits for pulse end
//   CARREGA   | result and saturation flag loaded
//   FINAL     | pronto pulse
module contador_cm_param
    import contador_cm_param_pkg::*;
#(
    parameter int TICK_DIV    = 2941,
    parameter int N_DIGITS    = 3,
    parameter int MAX_CM      = 400,
    parameter int ROUND       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      pulso,
    output logic [BCD_W*N_DIGITS-1:0] medida,
    output logic                      pronto,
    output logic                      estouro,
    output logic                      ocupado,
    output logic [2:0]                db_estado
);

    localparam int QW = BCD_W * N_DIGITS;
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TC   = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(TICK_DIV / 2);

    estado_t        state, nxt;
    logic           p;
    logic           armado;
    logic           saturou;
    logic [CW-1:0]  cnt;
    logic           tick;
    logic           round_up;
    logic           zera, conta;
    logic [QW-1:0]  bcd;
    logic           eh_max;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign p = pulso;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sync <= '0;
                end else begin
                    sync[0] <= pulso;
                    for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
                end
            end
            assign p = sync[SYNC_STAGES-1];
        end
    endgenerate

    assign tick     = (cnt == TC);
    assign round_up = (ROUND != 0) && (cnt >= HALF) && !eh_max;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= INICIAL;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            INICIAL:   if (p && armado) nxt = ESPERA;
            ESPERA: begin
                if (!p)                 nxt = ARREDONDA;
                else if (tick && eh_max) nxt = ESTOURO;
                else if (tick)          nxt = CONTA;
            end
            CONTA:     nxt = ESPERA;
            ARREDONDA: nxt = CARREGA;
            ESTOURO:   if (!p) nxt = CARREGA;
            CARREGA:   nxt = FINAL;
            FINAL:     nxt = INICIAL;
            default:   nxt = INICIAL;
        endcase
    end

    always_comb begin
        ocupado   = (state != INICIAL);
        pronto    = (state == FINAL);
        db_estado = state;
        zera      = (state == INICIAL);
        conta     = (state == CONTA) || ((state == ARREDONDA) && round_up);
    end

    // Arming is consumed on start so a pulse must be seen low again before the next measurement.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            armado <= 1'b0;
        end else if (state == INICIAL) begin
            if (!p)          armado <= 1'b1;
            else if (armado) armado <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state == INICIAL) begin
            cnt <= '0;
        end else if (((state == ESPERA) || (state == CONTA)) && p) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            medida  <= '0;
            estouro <= 1'b0;
            saturou <= 1'b0;
        end else begin
            if (state == INICIAL)      saturou <= 1'b0;
            else if (state == ESTOURO) saturou <= 1'b1;
            if (state == CARREGA) begin
                medida  <= bcd;
                estouro <= saturou;
            end
        end
    end

    contador_bcd_n #(
        .N_DIGITS (N_DIGITS),
        .MAX_CM   (MAX_CM)
    ) u_bcd (
        .clock  (clock),
        .reset  (reset),
        .zera   (zera),
        .conta  (conta),
        .q      (bcd),
        .eh_max (eh_max)
    );

endmodule

// File: tb/tb_contador_cm_param.sv
// Bench for contador_cm_param: three parameterisations share one pulso/reset stream.
module tb_contador_cm_param;

    localparam int TD   = 4;
    localparam int ND   = 3;
    localparam int MAXC = 400;
    localparam int W    = 4 * ND;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         pulso = 1'b0;
    logic [W-1:0] med [3];
    logic         pr  [3];
    logic         est [3];
    logic         ocu [3];
    logic [2:0]   dbe [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pcnt [3] = '{0, 0, 0};
    int pcyc [3] = '{0, 0, 0};

    typedef struct {
        int           h;
        logic [W-1:0] e_round;
        logic [W-1:0] e_trunc;
        logic         e_sat;
    } vec_t;

    vec_t vecs [$];

    // u0: rounding, no sync; u1: truncating, no sync; u2: rounding, two sync stages
    contador_cm_param #(.TICK_DIV(TD), .N_DIGITS(ND), .MAX_CM(MAXC), .ROUND(1), .SYNC_STAGES(0)) u0 (
        .clock(clock), .reset(reset), .pulso(pulso), .medida(med[0]), .pronto(pr[0]),
        .estouro(est[0]), .ocupado(ocu[0]), .db_estado(dbe[0]));
    contador_cm_param #(.TICK_DIV(TD), .N_DIGITS(ND), .MAX_CM(MAXC), .ROUND(0), .SYNC_STAGES(0)) u1 (
        .clock(clock), .reset(reset), .pulso(pulso), .medida(med[1]), .pronto(pr[1]),
        .estouro(est[1]), .ocupado(ocu[1]), .db_estado(dbe[1]));
    contador_cm_param #(.TICK_DIV(TD), .N_DIGITS(ND), .MAX_CM(MAXC), .ROUND(1), .SYNC_STAGES(2)) u2 (
        .clock(clock), .reset(reset), .pulso(pulso), .medida(med[2]), .pronto(pr[2]),
        .estouro(est[2]), .ocupado(ocu[2]), .db_estado(dbe[2]));

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (pr[i] === 1'b1) begin
                pcnt[i] <= pcnt[i] + 1;
                pcyc[i] <= cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: h clocks of p=1 give h-1 divider steps; whole steps are cm, the rest is the residual.
    // k = clocks from the first low sample to pronto (one extra if the pulse ended on a tick).
    function automatic void model(input int h, input bit rnd, output int cm, output bit sat, output int k);
        int t, r;
        t = (h - 1) / TD;
        r = (h - 1) % TD;
        if (t > MAXC) begin
            cm  = MAXC;
            sat = 1'b1;
            k   = 1;
        end else begin
            cm  = t + ((rnd && (r >= TD / 2) && (t < MAXC)) ? 1 : 0);
            sat = 1'b0;
            k   = ((r == 0) && (t > 0)) ? 3 : 2;
        end
    endfunction

    task automatic measure(input string name, input int h, input logic [W-1:0] e_round,
                           input logic [W-1:0] e_trunc, input logic e_sat, input int k);
        int base [3];
        int f;
        logic [W-1:0] em [3];
        em[0] = e_round;
        em[1] = e_trunc;
        em[2] = e_round;
        for (int i = 0; i < 3; i++) base[i] = pcnt[i];
        @(negedge clock);
        pulso = 1'b1;
        if (h >= 4) begin
            repeat (3) @(negedge clock);
            check($sformatf("%s ocupado_mid", name), 32'(ocu[0]), 32'd1);
            repeat (h - 3) @(negedge clock);
        end else begin
            repeat (h) @(negedge clock);
        end
        pulso = 1'b0;
        f = cyc;
        repeat (40) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s pronto_count u%0d", name, i), 32'(pcnt[i] - base[i]), 32'd1);
            check($sformatf("%s medida u%0d", name, i), 32'(med[i]), 32'(em[i]));
            check($sformatf("%s estouro u%0d", name, i), 32'(est[i]), 32'(e_sat));
            check($sformatf("%s pronto_cycle u%0d", name, i), 32'(pcyc[i]),
                  32'(f + 1 + k + ((i == 2) ? 2 : 0)));
        end
        check($sformatf("%s ocupado_idle", name), 32'(ocu[0]), 32'd0);
        check($sformatf("%s db_estado_idle", name), 32'(dbe[0]), 32'd0);
    endtask

    initial begin
        int cm1, cm0, k, h;
        bit s;
        int base [3];

        vecs.push_back('{41,   12'h010, 12'h010, 1'b0});
        vecs.push_back('{43,   12'h011, 12'h010, 1'b0});
        vecs.push_back('{42,   12'h010, 12'h010, 1'b0});
        vecs.push_back('{2000, 12'h400, 12'h400, 1'b1});
        vecs.push_back('{41,   12'h010, 12'h010, 1'b0});
        vecs.push_back('{397,  12'h099, 12'h099, 1'b0});
        vecs.push_back('{401,  12'h100, 12'h100, 1'b0});
        vecs.push_back('{1,    12'h000, 12'h000, 1'b0});
        vecs.push_back('{6,    12'h001, 12'h001, 1'b0});
        vecs.push_back('{7,    12'h002, 12'h001, 1'b0});
        vecs.push_back('{1599, 12'h400, 12'h399, 1'b0});
        vecs.push_back('{1601, 12'h400, 12'h400, 1'b0});
        vecs.push_back('{1603, 12'h400, 12'h400, 1'b0});
        vecs.push_back('{1605, 12'h400, 12'h400, 1'b1});

        repeat (2) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset medida u%0d", i), 32'(med[i]), 32'd0);
            check($sformatf("reset pronto u%0d", i), 32'(pr[i]), 32'd0);
            check($sformatf("reset estouro u%0d", i), 32'(est[i]), 32'd0);
            check($sformatf("reset ocupado u%0d", i), 32'(ocu[i]), 32'd0);
            check($sformatf("reset db_estado u%0d", i), 32'(dbe[i]), 32'd0);
        end
        reset = 1'b1;
        repeat (5) @(negedge clock);

        foreach (vecs[j]) begin
            model(vecs[j].h, 1'b1, cm1, s, k);
            measure($sformatf("vec%0d_h%0d", j, vecs[j].h), vecs[j].h,
                    vecs[j].e_round, vecs[j].e_trunc, vecs[j].e_sat, k);
        end

        // Pulse already high at reset release must not be measured (unsynchronised instances).
        reset = 1'b0;
        pulso = 1'b1;
        @(negedge clock);
        check("held reset medida", 32'(med[0]), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) base[i] = pcnt[i];
        repeat (60) @(negedge clock);
        for (int i = 0; i < 2; i++)
            check($sformatf("held no_pronto u%0d", i), 32'(pcnt[i] - base[i]), 32'd0);
        check("held ocupado", 32'(ocu[0]), 32'd0);
        pulso = 1'b0;
        repeat (30) @(negedge clock);
        measure("after_held_41", 41, 12'h010, 12'h010, 1'b0, 3);

        // Saturate, then abort the next pulse with reset at cycle 20.
        model(1605, 1'b1, cm1, s, k);
        measure("sat_before_abort", 1605, 12'h400, 12'h400, 1'b1, k);
        @(negedge clock);
        pulso = 1'b1;
        repeat (20) @(negedge clock);
        for (int i = 0; i < 3; i++) base[i] = pcnt[i];
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort medida u%0d", i), 32'(med[i]), 32'd0);
            check($sformatf("abort estouro u%0d", i), 32'(est[i]), 32'd0);
            check($sformatf("abort ocupado u%0d", i), 32'(ocu[i]), 32'd0);
            check($sformatf("abort db_estado u%0d", i), 32'(dbe[i]), 32'd0);
        end
        reset = 1'b1;
        repeat (30) @(negedge clock);
        pulso = 1'b0;
        repeat (30) @(negedge clock);
        for (int i = 0; i < 2; i++)
            check($sformatf("abort no_pronto u%0d", i), 32'(pcnt[i] - base[i]), 32'd0);
        measure("after_abort_43", 43, 12'h011, 12'h010, 1'b0, 2);

        for (int n = 0; n < 30; n++) begin
            h = $urandom_range(1700, 1);
            model(h, 1'b1, cm1, s, k);
            model(h, 1'b0, cm0, s, k);
            measure($sformatf("rand%0d_h%0d", n, h), h, to_bcd(cm1), to_bcd(cm0), s, k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
